ioctl_upload_src: RTL

- Core-side data source for HPS ioctl upload transfers (NVRAM/hiscore save): the read-direction counterpart of the ROM download path.
- Services each HPS read strobe by fetching one byte from a game RAM window.
- Stretches the transfer with ioctl_wait until that byte is valid.
- Holds the game CPU paused for the whole upload.
- Sits between hps_io and the game RAM secondary port, beside the pause block.

---
 rtl/ioctl_upload_src.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ioctl_upload_src.sv
// ioctl_upload_src: serves HPS ioctl upload reads (NVRAM / hiscore save) from a
// window of game RAM. Each read strobe fetches one byte through the game RAM
// secondary port and holds ioctl_wait high until that byte is on ioctl_din.
// The game CPU is held paused for as long as the upload session is active.
module ioctl_upload_src #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] REGION_BASE = '0,
    parameter int                REGION_LEN  = 256,
    parameter int                RAM_LAT     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    input  logic              save_trigger,
    output logic              pause_req,
    input  logic              paused,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        FETCH   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Last latency-counter value before ram_data is sampled, and the value at
    // which the read intent is withdrawn (RAM_LAT cycles of ram_rd).
    localparam logic [2:0]  LAT_LAST   = 3'(RAM_LAT);
    localparam logic [2:0]  LAT_RD_END = 3'(RAM_LAT - 1);
    localparam logic [25:0] LEN_EXT    = 26'(REGION_LEN);

    state_t            state;
    logic [2:0]        lat_cnt;
    logic              oor_q;
    logic              save_q;
    logic              in_range;
    logic [ADDR_W-1:0] fetch_addr;

    // Full 25-bit offset compare so any offset beyond the window reads as 8'hFF.
    assign in_range   = {1'b0, ioctl_addr} < LEN_EXT;
    assign fetch_addr = REGION_BASE + ioctl_addr[ADDR_W-1:0];

    // Pause request follows the session level; save requests fire on a rising
    // save_trigger edge only while no upload is running.
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset_n) begin
            pause_req        <= 1'b0;
            save_q           <= 1'b0;
            ioctl_upload_req <= 1'b0;
        end else begin
            pause_req        <= ioctl_upload;
            save_q           <= save_trigger;
            ioctl_upload_req <= save_trigger & ~save_q & ~ioctl_upload;
        end
    end

    // Read-service FSM: accept strobe, wait for pause, fetch, present byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            oor_q      <= 1'b0;
            ioctl_din  <= 8'hFF;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
        end else if (!ioctl_upload) begin
            // Session ended: drop everything but keep the last byte on ioctl_din.
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            oor_q      <= 1'b0;
            ioctl_wait <= 1'b0;
            ram_rd     <= 1'b0;
        end else begin
            case (state)
                IDLE, PRESENT: begin
                    if (ioctl_rd) begin
                        ioctl_wait <= 1'b1;
                        lat_cnt    <= 3'd0;
                        if (!in_range) begin
                            // No RAM access; one wait cycle then 8'hFF.
                            oor_q <= 1'b1;
                            state <= FETCH;
                        end else begin
                            oor_q    <= 1'b0;
                            ram_addr <= fetch_addr;
                            if (paused) begin
                                state  <= FETCH;
                                ram_rd <= 1'b1;
                            end else begin
                                state <= SYNC;
                            end
                        end
                    end
                end
                SYNC: begin
                    if (paused) begin
                        state  <= FETCH;
                        ram_rd <= 1'b1;
                    end
                end
                FETCH: begin
                    // paused is deliberately not re-checked: pause_req already
                    // guarantees the CPU stays off the RAM.
                    if (oor_q) begin
                        ioctl_din  <= 8'hFF;
                        ioctl_wait <= 1'b0;
                        oor_q      <= 1'b0;
                        state      <= PRESENT;
                    end else if (lat_cnt == LAT_LAST) begin
                        ioctl_din  <= ram_data;
                        ioctl_wait <= 1'b0;
                        state      <= PRESENT;
                    end else begin
                        if (lat_cnt == LAT_RD_END) begin
                            ram_rd <= 1'b0;
                        end
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
